pe_pingpong_sequencer: RTL
==========================

# pe_pingpong_sequencer

Control sequencer for one processing element of the MLP neuron array. It fills the PE's two weight SRAM banks alternately (ping-pong) from a weight stream and steps the MAC datapath through one dot product per full bank. It drives the demux/mux bank selects, SRAM enables and addresses, and accumulator write/clear, and flags when the quantized PE output is valid. It replaces the PE's in-line controller and owns all PE handshakes.

## Interface
- INPUT_NUM, 4, weights/inputs per dot product; SRAM depth; must be ≥ 2
- ADDR_WIDTH, $clog2(INPUT_NUM), SRAM address width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- new_weight  input  1  weight word valid this cycle
- weight_ready  output  1  fill bank can accept a weight
- input_available  input  1  input word valid this cycle
- input_ready  output  1  compute side can accept an input
- demux_select  output  1  fill bank index (0 = sram1, 1 = sram2)
- sram1_write_enable, sram2_write_enable  output  1 each  bank write strobes
- sram1_write_address, sram2_write_address  output  ADDR_WIDTH each  write addresses
- read_enable  output  1  SRAM read strobe
- sram1_read_address, sram2_read_address  output  ADDR_WIDTH each  read addresses (both driven with the same value)
- mux_select  output  1  compute bank index
- adder_register_write_enable  output  1  accumulator load
- acc_clear  output  1  accumulator clear pulse
- out_valid  output  1  pe_out holds a finished dot product this cycle
- bank_full  output  2  per-bank full flags (bit0 = sram1)

## Operation
- Fill side:
  - Counter wr_cnt plus fill-bank pointer fill_bank.
  - weight_ready = !bank_full[fill_bank].
  - On new_weight && weight_ready, the selected bank's write_enable is high in the same cycle (combinational), its write address = wr_cnt, and wr_cnt increments.
  - new_weight while weight_ready is low is ignored.
  - When wr_cnt == INPUT_NUM-1 is written: set bank_full[fill_bank], wr_cnt → 0, and toggle fill_bank.
- Compute FSM: C_IDLE, C_RUN, C_LAST. Pointer comp_bank drives mux_select.
  - C_IDLE: if bank_full[comp_bank], pulse acc_clear and go to C_RUN with rd_cnt = 0.
  - C_RUN: input_ready = 1. On input_available: read_enable = 1, read addresses = rd_cnt, rd_cnt increments, and acc_pend is set for the next cycle. At rd_cnt == INPUT_NUM-1 with input_available, go to C_LAST.
  - adder_register_write_enable = acc_pend. This aligns with the registered SRAM read and the PE input register.
  - C_LAST: input_ready = 0. The final accumulate occurs and out_valid = 1. The bank is released (bank_full[comp_bank] cleared), comp_bank toggles, and the FSM returns to C_IDLE.
- Accumulator arithmetic and width are set by the PE; this block only sequences it.
- Simultaneous events:
  - A fill completing on one bank and a release on the other bank in the same cycle both take effect.
  - A write to a bank and a release of that same bank in one cycle cannot occur, because fill never targets a full bank.
- Reset mid-operation: all counters, pointers, flags and FSM state return to reset values next edge; partial fills and partial sums are discarded.
- Reset values: all outputs 0 except weight_ready = 1. fill_bank = comp_bank = 0, FSM in C_IDLE.

## Timing
- Fill: weight k of a bank is written in the same cycle it is offered. bank_full rises on the edge after the last write.
- Compute start: C_IDLE sees bank_full in the cycle after it rises and asserts acc_clear. The first input can be accepted the following cycle.
- Per input: read at cycle t, accumulate at t+1.
- Last input accepted at cycle t: out_valid at t+1 (C_LAST), bank released at t+2, next start evaluated in C_IDLE at t+2.
- Minimum dot product: INPUT_NUM + 2 cycles from acc_clear to out_valid inclusive, with input_available held high.
- Gaps in input_available stall rd_cnt. Gaps in new_weight stall wr_cnt. Neither has a timeout.

## Configuration
- PE_WEIGHT_REUSE_EN defined:
  - C_LAST does not release comp_bank if the other bank is not full. The FSM returns to C_IDLE and reruns the same weights against the next input vector.
  - Release and toggle happen only once the other bank is full.
- Undefined: the bank is released after every dot product, as described above.

## Test plan
- Reset, INPUT_NUM = 4: all outputs 0, weight_ready = 1, bank_full = 2'b00.
- 4 consecutive new_weight: sram1 writes addresses 0–3, then bank_full = 01, demux_select = 1, acc_clear pulses one cycle later.
- Bank0 full, 4 back-to-back input_available: read addresses 0,1,2,3; adder_register_write_enable high for 4 cycles offset +1; out_valid one cycle after the last read; bank_full[0] clears.
- Fill both banks (8 weights) with compute stalled: weight_ready drops after the 8th write, and a 9th new_weight is ignored with no write strobe.
- Release of bank0 and completion of bank1 in the same cycle: bank_full goes 01→10, and compute starts on bank1.
- reset asserted after 2 of 4 inputs: FSM in C_IDLE, rd_cnt = wr_cnt = 0, bank_full = 00, no out_valid. With PE_WEIGHT_REUSE_EN, two input vectors on bank0 give two out_valid pulses with bank_full[0] staying 1.

Source files
------------

// File: rtl/pe_pingpong_sequencer.sv
// pe_pingpong_sequencer
//   Control sequencer for one MLP processing element. Two weight SRAM banks
//   are filled alternately from the weight stream. Each full bank drives one
//   dot product through the MAC datapath, and the bank is then released for
//   refill.
//
//   Fill side   : new_weight/weight_ready handshake, demux_select,
//                 sramN_write_enable, sramN_write_address.
//   Compute side: input_available/input_ready handshake, read_enable,
//                 sramN_read_address, mux_select,
//                 adder_register_write_enable, acc_clear, out_valid.
//   Status      : bank_full[1:0] (bit0 = sram1).
//
//   Build option PE_WEIGHT_REUSE_EN: a finished bank is kept and rerun
//   against the next input vector. It is released only once the other bank
//   is full.
//
//   Reset is synchronous and active-high on clk.
module pe_pingpong_sequencer #(
  parameter int INPUT_NUM  = 4,
  parameter int ADDR_WIDTH = $clog2(INPUT_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_weight,
  output logic                  weight_ready,
  input  logic                  input_available,
  output logic                  input_ready,
  output logic                  demux_select,
  output logic                  sram1_write_enable,
  output logic                  sram2_write_enable,
  output logic [ADDR_WIDTH-1:0] sram1_write_address,
  output logic [ADDR_WIDTH-1:0] sram2_write_address,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] sram1_read_address,
  output logic [ADDR_WIDTH-1:0] sram2_read_address,
  output logic                  mux_select,
  output logic                  adder_register_write_enable,
  output logic                  acc_clear,
  output logic                  out_valid,
  output logic [1:0]            bank_full
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(INPUT_NUM - 1);

  typedef enum logic [1:0] {C_IDLE, C_RUN, C_LAST} cstate_t;

  cstate_t               state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt;
  logic                  fill_bank, comp_bank;
  logic                  acc_pend;
  logic [1:0]            full_q, full_nxt;
  logic                  wr_fire, fill_done, rd_fire, release_bank;

  // ---------------- fill side ----------------
  assign weight_ready        = !full_q[fill_bank];
  assign wr_fire             = new_weight && weight_ready;
  assign fill_done           = wr_fire && (wr_cnt == LAST_IDX);
  assign demux_select        = fill_bank;
  assign sram1_write_enable  = wr_fire && !fill_bank;
  assign sram2_write_enable  = wr_fire &&  fill_bank;
  assign sram1_write_address = wr_cnt;
  assign sram2_write_address = wr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt    <= '0;
      fill_bank <= 1'b0;
    end else if (wr_fire) begin
      if (fill_done) begin
        wr_cnt    <= '0;
        fill_bank <= !fill_bank;
      end else begin
        wr_cnt    <= wr_cnt + 1'b1;
      end
    end
  end

  // Fill only ever targets an empty bank and release only a full one, so
  // set and clear can never hit the same bit in one cycle.
  always_comb begin
    full_nxt = full_q;
    if (fill_done)    full_nxt[fill_bank] = 1'b1;
    if (release_bank) full_nxt[comp_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) full_q <= '0;
    else       full_q <= full_nxt;
  end

  assign bank_full = full_q;

  // ---------------- compute side ----------------
  always_comb begin
    state_nxt    = state;
    input_ready  = 1'b0;
    rd_fire      = 1'b0;
    acc_clear    = 1'b0;
    out_valid    = 1'b0;
    release_bank = 1'b0;
    unique case (state)
      C_IDLE: begin
        if (full_q[comp_bank]) begin
          acc_clear = 1'b1;
          state_nxt = C_RUN;
        end
      end
      C_RUN: begin
        input_ready = 1'b1;
        rd_fire     = input_available;
        if (rd_fire && rd_cnt == LAST_IDX) state_nxt = C_LAST;
      end
      C_LAST: begin
        // Final accumulate lands this cycle (acc_pend), so pe_out is done.
        out_valid = 1'b1;
`ifdef PE_WEIGHT_REUSE_EN
        release_bank = full_q[!comp_bank];
`else
        release_bank = 1'b1;
`endif
        state_nxt = C_IDLE;
      end
      default: state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= C_IDLE;
      rd_cnt    <= '0;
      acc_pend  <= 1'b0;
      comp_bank <= 1'b0;
    end else begin
      state    <= state_nxt;
      // The SRAM read is registered, so the accumulate trails the read by one cycle.
      acc_pend <= rd_fire;
      if (acc_clear)
        rd_cnt <= '0;
      else if (rd_fire)
        rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + 1'b1;
      if (release_bank) comp_bank <= !comp_bank;
    end
  end

  assign read_enable                 = rd_fire;
  assign sram1_read_address          = rd_cnt;
  assign sram2_read_address          = rd_cnt;
  assign mux_select                  = comp_bank;
  assign adder_register_write_enable = acc_pend;

endmodule
